alu_sequencer: RTL and testbench

Controller that sequences the calculator's 16-bit ALU datapath. It captures operands A and B from the shift-register entry value and starts an operation on an "equals" pulse. ADD/SUB complete in one cycle. MUL (shift-add) and DIV (restoring) run iteratively over 16 cycles. It owns the busy/done handshake, the error flag and the 32-bit value shown on the seven-segment bank. It sits between the button edge detectors and the `ssdec` display decoders in `top`.

---
 rtl/alu_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Sequencer for the calculator's W-bit ALU: operand capture, one-cycle ADD/SUB,
// 16-step shift-add MUL and restoring DIV, busy/done handshake, error flag and display value.
module alu_sequencer #(
    parameter int W = 16
) (
    input  logic           hz100,
    input  logic           reset,
    input  logic           clear,
    input  logic           load_a,
    input  logic           load_b,
    input  logic           equal,
    input  logic [3:0]     opcode,
    input  logic [W-1:0]   operand,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [2*W-1:0] result,
    output logic [2*W-1:0] disp
);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [4:0] LAST_STEP = 5'd15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HAVE_A = 3'd1,
        ST_HAVE_B = 3'd2,
        ST_READY  = 3'd3,
        ST_EXEC   = 3'd4
    } state_t;

    state_t         state_r, state_nx_s;
    logic [W-1:0]   a_r, b_r;
    logic           a_valid_r, b_valid_r;
    logic [3:0]     op_r;
    logic [4:0]     cnt_r;
    logic [2*W-1:0] acc_r, mcand_r;
    logic [W-1:0]   mplier_r, rem_r, quot_r;
    logic           busy_r, done_r, err_r;
    logic [2*W-1:0] result_r, disp_r;

    logic           load_a_s, load_b_s, start_s, step_s, finish_s, iter_op_s;
    logic [2*W-1:0] mul_acc_nx_s, result_nx_s;
    logic [W:0]     shifted_s, diff_s;
    logic [W-1:0]   rem_nx_s, quot_nx_s;
    logic           err_nx_s;

    assign iter_op_s = (op_r == OP_MUL) || ((op_r == OP_DIV) && (b_r != {W{1'b0}}));

    // One shift-add / restoring-subtract step and the value written on completion.
    always_comb begin
        mul_acc_nx_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
        shifted_s    = {rem_r, quot_r[W-1]};
        diff_s       = shifted_s - {1'b0, b_r};
        rem_nx_s     = shifted_s[W-1:0];
        quot_nx_s    = {quot_r[W-2:0], 1'b0};
        if (!diff_s[W]) begin
            rem_nx_s  = diff_s[W-1:0];
            quot_nx_s = {quot_r[W-2:0], 1'b1};
        end else begin
            rem_nx_s  = shifted_s[W-1:0];
        end
        result_nx_s = {2*W{1'b0}};
        err_nx_s    = 1'b0;
        case (op_r)
            OP_ADD: result_nx_s = {{W{1'b0}}, a_r} + {{W{1'b0}}, b_r};
            OP_SUB: result_nx_s = {{W{1'b0}}, a_r} - {{W{1'b0}}, b_r};
            OP_MUL: result_nx_s = mul_acc_nx_s;
            OP_DIV: begin
                if (b_r == {W{1'b0}}) begin
                    err_nx_s = 1'b1;
                end else begin
                    result_nx_s = {{W{1'b0}}, quot_nx_s};
                end
            end
            default: err_nx_s = 1'b1;
        endcase
    end

    // Next-state and control decode; load_a > load_b > equal outside EXEC.
    always_comb begin
        state_nx_s = state_r;
        load_a_s   = 1'b0;
        load_b_s   = 1'b0;
        start_s    = 1'b0;
        step_s     = 1'b0;
        finish_s   = 1'b0;
        case (state_r)
            ST_EXEC: begin
                if (iter_op_s) begin
                    step_s = 1'b1;
                    if (cnt_r == LAST_STEP) begin
                        finish_s   = 1'b1;
                        state_nx_s = ST_READY;
                    end else begin
                        state_nx_s = ST_EXEC;
                    end
                end else begin
                    finish_s   = 1'b1;
                    state_nx_s = ST_READY;
                end
            end
            default: begin
                if (load_a) begin
                    load_a_s = 1'b1;
                    case (state_r)
                        ST_IDLE:   state_nx_s = ST_HAVE_A;
                        ST_HAVE_B: state_nx_s = ST_READY;
                        default:   state_nx_s = state_r;
                    endcase
                end else if (load_b) begin
                    load_b_s = 1'b1;
                    case (state_r)
                        ST_IDLE:   state_nx_s = ST_HAVE_B;
                        ST_HAVE_A: state_nx_s = ST_READY;
                        default:   state_nx_s = state_r;
                    endcase
                end else if (equal && (state_r == ST_READY) && a_valid_r && b_valid_r) begin
                    start_s    = 1'b1;
                    state_nx_s = ST_EXEC;
                end else begin
                    state_nx_s = state_r;
                end
            end
        endcase
    end

    // State register; clear aborts any operation immediately.
    always_ff @(posedge hz100) begin
        if (reset || clear) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Operand, iteration and output registers.
    always_ff @(posedge hz100) begin
        if (reset || clear) begin
            a_r       <= {W{1'b0}};
            b_r       <= {W{1'b0}};
            a_valid_r <= 1'b0;
            b_valid_r <= 1'b0;
            op_r      <= 4'd0;
            cnt_r     <= 5'd0;
            acc_r     <= {2*W{1'b0}};
            mcand_r   <= {2*W{1'b0}};
            mplier_r  <= {W{1'b0}};
            rem_r     <= {W{1'b0}};
            quot_r    <= {W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            result_r  <= {2*W{1'b0}};
            disp_r    <= {2*W{1'b0}};
        end else begin
            done_r <= 1'b0;
            if (load_a_s) begin
                a_r       <= operand;
                a_valid_r <= 1'b1;
                disp_r    <= {{W{1'b0}}, operand};
            end
            if (load_b_s) begin
                b_r       <= operand;
                b_valid_r <= 1'b1;
                disp_r    <= {{W{1'b0}}, operand};
            end
            if (start_s) begin
                op_r     <= opcode;
                err_r    <= 1'b0;
                busy_r   <= 1'b1;
                cnt_r    <= 5'd0;
                acc_r    <= {2*W{1'b0}};
                mcand_r  <= {{W{1'b0}}, a_r};
                mplier_r <= b_r;
                rem_r    <= {W{1'b0}};
                quot_r   <= a_r;
            end
            if (step_s) begin
                acc_r    <= mul_acc_nx_s;
                mcand_r  <= {mcand_r[2*W-2:0], 1'b0};
                mplier_r <= {1'b0, mplier_r[W-1:1]};
                rem_r    <= rem_nx_s;
                quot_r   <= quot_nx_s;
                cnt_r    <= cnt_r + 5'd1;
            end
            if (finish_s) begin
                result_r <= result_nx_s;
                disp_r   <= result_nx_s;
                err_r    <= err_nx_s;
                done_r   <= 1'b1;
                busy_r   <= 1'b0;
            end
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign err    = err_r;
    assign result = result_r;
    assign disp   = disp_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer; inputs change and outputs are sampled on negedge.
module tb_alu_sequencer;

    localparam int W = 16;

    logic           hz100 = 1'b0;
    logic           reset = 1'b1;
    logic           clear = 1'b0;
    logic           load_a = 1'b0;
    logic           load_b = 1'b0;
    logic           equal = 1'b0;
    logic [3:0]     opcode = 4'd0;
    logic [W-1:0]   operand = '0;
    logic           busy, done, err;
    logic [2*W-1:0] result, disp;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.W(W)) dut (
        .hz100(hz100), .reset(reset), .clear(clear), .load_a(load_a), .load_b(load_b),
        .equal(equal), .opcode(opcode), .operand(operand), .busy(busy), .done(done),
        .err(err), .result(result), .disp(disp)
    );

    always #5 hz100 = ~hz100;

    task automatic pulse_a(input logic [W-1:0] v);
        @(negedge hz100); load_a = 1'b1; operand = v;
        @(negedge hz100); load_a = 1'b0;
    endtask

    task automatic pulse_b(input logic [W-1:0] v);
        @(negedge hz100); load_b = 1'b1; operand = v;
        @(negedge hz100); load_b = 1'b0;
    endtask

    // Leaves the bench at the negedge right after the sampling edge E.
    task automatic pulse_eq(input logic [3:0] op);
        @(negedge hz100); opcode = op; equal = 1'b1;
        @(negedge hz100); equal = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge hz100);
        reset = 1'b0;
        checks++;
        if ({busy, done, err} !== 3'b000 || result !== 32'd0 || disp !== 32'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b err=%b result=%h disp=%h, want all 0", busy, done, err, result, disp);
        end
    endtask

    task automatic test_sub();
        pulse_a(16'h0003);
        checks++;
        if (disp !== 32'h0000_0003) begin errors++; $display("FAIL load_a_disp: got %h want 00000003", disp); end
        pulse_b(16'h0005);
        checks++;
        if (disp !== 32'h0000_0005) begin errors++; $display("FAIL load_b_disp: got %h want 00000005", disp); end
        pulse_eq(4'b0010);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL sub_busy: busy=%b done=%b want 1 0", busy, done); end
        @(negedge hz100);
        checks++;
        if (result !== 32'hFFFF_FFFE || disp !== 32'hFFFF_FFFE || done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sub_result: result=%h disp=%h done=%b err=%b busy=%b want FFFFFFFE FFFFFFFE 1 0 0", result, disp, done, err, busy);
        end
        @(negedge hz100);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL sub_done_width: done=%b want 0", done); end
    endtask

    task automatic test_iter(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                             input logic [2*W-1:0] exp, input string name);
        int cyc;
        pulse_a(a);
        pulse_b(b);
        pulse_eq(op);
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            if (done !== 1'b0) begin
                checks++; errors++;
                $display("FAIL %s_done_with_busy: done=%b while busy", name, done);
            end
            @(negedge hz100);
        end
        checks++;
        if (cyc != 16) begin errors++; $display("FAIL %s_latency: busy cycles %0d want 16", name, cyc); end
        checks++;
        if (result !== exp || disp !== exp || done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s_result: result=%h disp=%h done=%b err=%b want %h %h 1 0", name, result, disp, done, err, exp, exp);
        end
        @(negedge hz100);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL %s_done_width: done=%b want 0", name, done); end
    endtask

    task automatic test_div_zero();
        pulse_b(16'h0000);
        pulse_eq(4'b0011);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL div0_busy: busy=%b want 1", busy); end
        @(negedge hz100);
        checks++;
        if (result !== 32'd0 || err !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL div0_result: result=%h err=%b done=%b busy=%b want 0 1 1 0", result, err, done, busy);
        end
    endtask

    task automatic test_illegal();
        pulse_a(16'h0009);
        pulse_b(16'h0001);
        pulse_eq(4'b0111);
        @(negedge hz100);
        checks++;
        if (result !== 32'd0 || err !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL illegal_op: result=%h err=%b done=%b want 0 1 1", result, err, done);
        end
        pulse_eq(4'b0001);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL add_clears_err: err=%b busy=%b want 0 1", err, busy); end
        @(negedge hz100);
        checks++;
        if (result !== 32'h0000_000A || err !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL add_result: result=%h err=%b done=%b want 0000000A 0 1", result, err, done);
        end
    endtask

    task automatic test_clear_abort();
        int seen_done;
        pulse_a(16'h1234);
        pulse_b(16'h5678);
        pulse_eq(4'b0100);
        repeat (7) @(negedge hz100);
        clear = 1'b1;
        @(negedge hz100);
        clear = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || disp !== 32'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL clear_abort: busy=%b done=%b result=%h disp=%h err=%b want 0 0 0 0 0", busy, done, result, disp, err);
        end
        seen_done = 0;
        pulse_eq(4'b0001);
        repeat (20) begin
            if (busy !== 1'b0 || done !== 1'b0) seen_done++;
            @(negedge hz100);
        end
        checks++;
        if (seen_done != 0) begin errors++; $display("FAIL clear_equal_ignored: active cycles %0d want 0", seen_done); end
        pulse_a(16'h0002);
        pulse_eq(4'b0001);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL have_a_equal_ignored: busy=%b want 0", busy); end
        pulse_b(16'h0003);
        pulse_eq(4'b0001);
        @(negedge hz100);
        checks++;
        if (result !== 32'h0000_0005 || done !== 1'b1) begin
            errors++;
            $display("FAIL reload_add: result=%h done=%b want 00000005 1", result, done);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge hz100);
        opcode = 4'b0001; load_a = 1'b1; equal = 1'b1; operand = 16'h0007;
        @(negedge hz100);
        load_a = 1'b0; equal = 1'b0;
        checks++;
        if (busy !== 1'b0 || disp !== 32'h0000_0007) begin
            errors++;
            $display("FAIL load_a_over_equal: busy=%b disp=%h want 0 00000007", busy, disp);
        end
        @(negedge hz100);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL dropped_equal: busy=%b done=%b want 0 0", busy, done); end
        pulse_eq(4'b0100);
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            load_a  = (cyc == 4);
            operand = 16'h00FF;
            @(negedge hz100);
        end
        load_a = 1'b0;
        checks++;
        if (result !== 32'h0000_0015 || disp !== 32'h0000_0015 || done !== 1'b1 || cyc != 16) begin
            errors++;
            $display("FAIL load_in_exec_mul: result=%h disp=%h done=%b cycles=%0d want 00000015 00000015 1 16", result, disp, done, cyc);
        end
        opcode = 4'b0001; equal = 1'b1;
        @(negedge hz100);
        equal = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL equal_after_done: busy=%b done=%b want 1 0", busy, done); end
        @(negedge hz100);
        checks++;
        if (result !== 32'h0000_000A || done !== 1'b1) begin
            errors++;
            $display("FAIL a_kept_after_exec: result=%h done=%b want 0000000A 1", result, done);
        end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_iter(16'h1234, 16'h5678, 4'b0100, 32'h0626_0060, "mul_a");
        test_iter(16'hFFFF, 16'hFFFF, 4'b0100, 32'hFFFE_0001, "mul_max");
        test_iter(16'hFFFF, 16'h0003, 4'b0011, 32'h0000_5555, "div");
        test_div_zero();
        test_illegal();
        test_iter(16'h0064, 16'h0007, 4'b0011, 32'h0000_000E, "div_small");
        test_clear_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
